// File: rtl/irrig_pkg.sv
// Shared types and constants for the irrigation timer controller:
// FSM encoding, BCD minute presets and the tank-level validity rule.
package irrig_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_ARM  = 3'd2,
      ST_RUN  = 3'd3,
      ST_HALT = 3'd4,
      ST_DONE = 3'd5,
      ST_LOWW = 3'd6
   } state_t;

   typedef struct packed {
      logic [1:0] dz;
      logic [3:0] und;
   } preset_t;

   // Drip (mode_gt) presets
   localparam preset_t PRESET_GT_H = '{dz: 2'd3, und: 4'd0};
   localparam preset_t PRESET_GT_M = '{dz: 2'd2, und: 4'd0};
   localparam preset_t PRESET_GT_L = '{dz: 2'd1, und: 4'd0};
   // Sprinkler (mode_as) presets
   localparam preset_t PRESET_AS_H = '{dz: 2'd1, und: 4'd5};
   localparam preset_t PRESET_AS_M = '{dz: 2'd1, und: 4'd0};
   localparam preset_t PRESET_AS_L = '{dz: 2'd0, und: 4'd5};

   // A level code is trustworthy only when it is monotone: h implies m, m implies l.
   function automatic logic level_valid(input logic h, input logic m, input logic l);
      return (m | ~h) & (l | ~m);
   endfunction

   function automatic preset_t preset_lookup(input logic drip, input logic h, input logic m);
      preset_t p;
      if (drip) p = h ? PRESET_GT_H : (m ? PRESET_GT_M : PRESET_GT_L);
      else      p = h ? PRESET_AS_H : (m ? PRESET_AS_M : PRESET_AS_L);
      return p;
   endfunction

endpackage

// File: rtl/irrigation_timer_ctrl_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus a registered
// rising-edge pulse taken from the synchronized value.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;

   // NOTE: flops are written with <= so every stage samples its neighbour's pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise_o = rise_q;

endmodule

// File: rtl/irrigation_timer_ctrl.sv
// Initiator side of the mm:ss countdown: picks a minutes preset from tank level
// and mode, loads and arms the timer, and holds the valve open until it reaches zero.
module irrigation_timer_ctrl
   import irrig_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DONE_HOLD   = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       lvl_h,
   input  logic       lvl_m,
   input  logic       lvl_l,
   input  logic       mode_as,
   input  logic       mode_gt,
   input  logic       start,
   input  logic       stop,
   input  logic       reach_zero,
   output logic       load,
   output logic [1:0] preset_dz_min,
   output logic [3:0] preset_und_min,
   output logic       count_en,
   output logic       valve,
   output logic       alarm,
   output logic [2:0] state
);

   localparam int         N_ASYNC   = 7;
   localparam logic [3:0] DONE_LAST = 4'(DONE_HOLD - 1);

   logic [N_ASYNC-1:0] async_in, sync_all, rise_all;
   logic               unused_sync;

   assign async_in = {lvl_h, lvl_m, lvl_l, mode_as, mode_gt, start, stop};

   for (genvar i = 0; i < N_ASYNC; i++) begin : g_sync
      sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk    (clk),
         .rst_n  (rst_n),
         .d_i    (async_in[i]),
         .sync_o (sync_all[i]),
         .rise_o (rise_all[i])
      );
   end

   // Buttons only need their edges, sensors and mode only their levels.
   assign unused_sync = ^{sync_all[1:0], rise_all[6:2]};

   logic    stop_rise, start_rise;
   logic    gt_s, as_s, l_s, m_s, h_s;
   logic    mode_ok, water_ok;
   preset_t preset_sel;

   assign stop_rise  = rise_all[0];
   assign start_rise = rise_all[1];
   assign gt_s       = sync_all[2];
   assign as_s       = sync_all[3];
   assign l_s        = sync_all[4];
   assign m_s        = sync_all[5];
   assign h_s        = sync_all[6];

   assign mode_ok    = as_s ^ gt_s;
   assign water_ok   = level_valid(h_s, m_s, l_s) & l_s;
   assign preset_sel = preset_lookup(gt_s, h_s, m_s);

   state_t     state_q, state_d;
   logic [3:0] done_cnt_q, done_cnt_d;
   preset_t    preset_q;
   logic       load_q, count_en_q, valve_q, alarm_q;

   // NOTE: defaults come first so every path assigns every output and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      done_cnt_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (start_rise && mode_ok) state_d = water_ok ? ST_LOAD : ST_LOWW;
         end
         ST_LOAD: state_d = ST_ARM;
         ST_ARM:  state_d = ST_RUN;
         ST_RUN: begin
            // stop outranks a level fault, which outranks the timer finishing
            if (stop_rise)       state_d = ST_DONE;
            else if (!water_ok)  state_d = ST_HALT;
            else if (reach_zero) state_d = ST_DONE;
         end
         ST_HALT: begin
            if (stop_rise)     state_d = ST_DONE;
            else if (water_ok) state_d = ST_RUN;
         end
         ST_DONE: begin
            if (tick_1hz && done_cnt_q == DONE_LAST) state_d = ST_IDLE;
            else done_cnt_d = done_cnt_q + 4'(tick_1hz);
         end
         ST_LOWW: begin
            if (water_ok) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they switch on the same edge as the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         done_cnt_q <= '0;
         preset_q   <= '0;
         load_q     <= 1'b0;
         count_en_q <= 1'b0;
         valve_q    <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_cnt_q <= done_cnt_d;
         load_q     <= (state_d == ST_LOAD);
         count_en_q <= (state_d == ST_RUN);
         valve_q    <= (state_d == ST_RUN);
         alarm_q    <= (state_d == ST_HALT) || (state_d == ST_LOWW);
         if (state_d == ST_LOAD) preset_q <= preset_sel;
      end
   end

   assign state          = state_q;
   assign load           = load_q;
   assign preset_dz_min  = preset_q.dz;
   assign preset_und_min = preset_q.und;
   assign count_en       = count_en_q;
   assign valve          = valve_q;
   assign alarm          = alarm_q;

endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
// Self-checking bench for irrigation_timer_ctrl with a behavioural countdown
// timer on the far side of the load/count/reach_zero interface.
module tb_irrigation_timer_ctrl;

   localparam int SYNC_STAGES = 2;
   localparam int DONE_HOLD   = 5;
   localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_ARM = 3'd2, S_RUN = 3'd3,
                          S_HALT = 3'd4, S_DONE = 3'd5, S_LOWW = 3'd6;

   logic       clk = 1'b0, rst_n = 1'b0, tick_1hz = 1'b0;
   logic       lvl_h = 1'b0, lvl_m = 1'b0, lvl_l = 1'b0;
   logic       mode_as = 1'b0, mode_gt = 1'b0, start = 1'b0, stop = 1'b0;
   logic       reach_zero;
   logic       load, count_en, valve, alarm;
   logic [1:0] preset_dz_min;
   logic [3:0] preset_und_min;
   logic [2:0] state;

   int n_checks = 0, n_fail = 0;
   int cyc = 0, tick_div = 4, load_count = 0, remaining = 0;
   bit timer_on = 1'b0, rz_force = 1'b0;

   irrigation_timer_ctrl #(.SYNC_STAGES(SYNC_STAGES), .DONE_HOLD(DONE_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
      .lvl_h(lvl_h), .lvl_m(lvl_m), .lvl_l(lvl_l),
      .mode_as(mode_as), .mode_gt(mode_gt), .start(start), .stop(stop),
      .reach_zero(reach_zero), .load(load),
      .preset_dz_min(preset_dz_min), .preset_und_min(preset_und_min),
      .count_en(count_en), .valve(valve), .alarm(alarm), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Countdown timer responder, kept in seconds.
   assign reach_zero = rz_force | (timer_on && remaining == 0);
   always @(posedge clk) begin
      if (load) remaining <= int'(preset_dz_min) * 600 + int'(preset_und_min) * 60;
      else if (count_en && tick_1hz && remaining > 0) remaining <= remaining - 1;
   end

   // Reference rules: minutes scale with the number of wetted sensors.
   function automatic int exp_minutes(input bit drip, input bit h, input bit m, input bit l);
      int wet = int'(h) + int'(m) + int'(l);
      return drip ? 10 * wet : 5 * wet;
   endfunction

   function automatic bit exp_level_ok(input bit h, input bit m, input bit l);
      return !(h && !m) && !(m && !l);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (load) load_count++;
      tick_1hz = (cyc % tick_div == 0);
   endtask

   task automatic settle();
      repeat (SYNC_STAGES + 2) step();
   endtask

   task automatic set_inputs(input bit as, input bit gt, input bit h, input bit m, input bit l);
      mode_as = as; mode_gt = gt; lvl_h = h; lvl_m = m; lvl_l = l;
   endtask

   task automatic press_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (state === target) begin ok = 1'b1; break; end
         step();
      end
      if (state === target) ok = 1'b1;
   endtask

   task automatic exit_to_idle(input string tag);
      bit ok;
      stop = 1'b1; step(); stop = 1'b0;
      wait_state(S_DONE, SYNC_STAGES + 4, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL %s_stop_done: state=%0d want %0d", tag, state, S_DONE); end
      wait_state(S_IDLE, (DONE_HOLD + 2) * tick_div + 4, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL %s_back_idle: state=%0d want %0d", tag, state, S_IDLE); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
      n_checks += 7;
      if (state !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", state, S_IDLE); end
      if (load !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %b want 0", load); end
      if (preset_dz_min !== 2'd0) begin n_fail++; $display("FAIL rst_dz: got %0d want 0", preset_dz_min); end
      if (preset_und_min !== 4'd0) begin n_fail++; $display("FAIL rst_und: got %0d want 0", preset_und_min); end
      if (count_en !== 1'b0) begin n_fail++; $display("FAIL rst_count_en: got %b want 0", count_en); end
      if (valve !== 1'b0) begin n_fail++; $display("FAIL rst_valve: got %b want 0", valve); end
      if (alarm !== 1'b0) begin n_fail++; $display("FAIL rst_alarm: got %b want 0", alarm); end
   endtask

   task automatic test_drip_high();
      int lat;
      set_inputs(0, 1, 1, 1, 1);
      settle();
      start = 1'b1;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         step(); lat++;
         if (load === 1'b1) break;
      end
      start = 1'b0;
      n_checks += 3;
      if (lat != SYNC_STAGES + 2 || load !== 1'b1)
         begin n_fail++; $display("FAIL drip_load_latency: got %0d cycles (load=%b) want %0d", lat, load, SYNC_STAGES + 2); end
      if (preset_dz_min !== 2'd3) begin n_fail++; $display("FAIL drip_dz: got %0d want 3", preset_dz_min); end
      if (preset_und_min !== 4'd0) begin n_fail++; $display("FAIL drip_und: got %0d want 0", preset_und_min); end
      step();
      n_checks += 3;
      if (state !== S_ARM) begin n_fail++; $display("FAIL drip_arm_state: got %0d want %0d", state, S_ARM); end
      if (load !== 1'b0) begin n_fail++; $display("FAIL drip_load_width: got %b want 0", load); end
      if (count_en !== 1'b0) begin n_fail++; $display("FAIL drip_arm_count_en: got %b want 0", count_en); end
      step();
      n_checks += 3;
      if (state !== S_RUN) begin n_fail++; $display("FAIL drip_run_state: got %0d want %0d", state, S_RUN); end
      if (count_en !== 1'b1) begin n_fail++; $display("FAIL drip_run_count_en: got %b want 1", count_en); end
      if (valve !== 1'b1) begin n_fail++; $display("FAIL drip_run_valve: got %b want 1", valve); end
      exit_to_idle("drip");
      n_checks++;
      if ({preset_dz_min, preset_und_min} !== {2'd3, 4'd0})
         begin n_fail++; $display("FAIL drip_preset_hold: got %0d/%0d want 3/0", preset_dz_min, preset_und_min); end
   endtask

   task automatic test_random_starts(input int n);
      for (int k = 0; k < n; k++) begin
         logic [1:0] md = 2'($urandom_range(0, 3));
         logic [2:0] lv = 3'($urandom_range(0, 7));
         bit mode_ok = md[0] ^ md[1];
         bit water = exp_level_ok(lv[2], lv[1], lv[0]) && lv[0];
         int mins = exp_minutes(md[1], lv[2], lv[1], lv[0]);
         logic [2:0] exp_st = !mode_ok ? S_IDLE : (water ? S_RUN : S_LOWW);
         int lc0;
         bit ok;
         set_inputs(md[0], md[1], lv[2], lv[1], lv[0]);
         settle();
         lc0 = load_count;
         press_start();
         repeat (SYNC_STAGES + 4) step();
         n_checks += 2;
         if (state !== exp_st)
            begin n_fail++; $display("FAIL rand%0d_state: mode=%b lvl=%b got %0d want %0d", k, md, lv, state, exp_st); end
         if (load_count != lc0 + ((exp_st == S_RUN) ? 1 : 0))
            begin n_fail++; $display("FAIL rand%0d_loads: got %0d want %0d", k, load_count - lc0, (exp_st == S_RUN) ? 1 : 0); end
         if (exp_st == S_RUN) begin
            n_checks++;
            if (int'(preset_dz_min) != mins / 10 || int'(preset_und_min) != mins % 10)
               begin n_fail++; $display("FAIL rand%0d_preset: got %0d/%0d want %0d/%0d", k, preset_dz_min, preset_und_min, mins / 10, mins % 10); end
            exit_to_idle("rand");
         end else if (exp_st == S_LOWW) begin
            n_checks++;
            if (alarm !== 1'b1) begin n_fail++; $display("FAIL rand%0d_loww_alarm: got %b want 1", k, alarm); end
            set_inputs(md[0], md[1], 1, 1, 1);
            wait_state(S_IDLE, SYNC_STAGES + 4, ok);
            n_checks++;
            if (!ok || alarm !== 1'b0) begin n_fail++; $display("FAIL rand%0d_loww_exit: state=%0d alarm=%b want %0d/0", k, state, alarm, S_IDLE); end
         end
      end
   endtask

   task automatic test_timer_run(input int n);
      timer_on = 1'b1;
      for (int k = 0; k < n; k++) begin
         bit drip = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         int wet = (k == 0) ? 1 : int'($urandom_range(1, 3));
         bit h = (wet >= 3), m = (wet >= 2);
         int mins = exp_minutes(drip, h, m, 1'b1);
         int done_ticks = 0;
         bit ok, hit = 1'b0;
         tick_div = int'($urandom_range(1, 2));
         set_inputs(!drip, drip, h, m, 1);
         settle();
         press_start();
         wait_state(S_RUN, SYNC_STAGES + 6, ok);
         n_checks += 2;
         if (!ok) begin n_fail++; $display("FAIL timer%0d_run: state=%0d want %0d", k, state, S_RUN); end
         if (int'(preset_dz_min) != mins / 10 || int'(preset_und_min) != mins % 10)
            begin n_fail++; $display("FAIL timer%0d_preset: got %0d/%0d want %0d/%0d", k, preset_dz_min, preset_und_min, mins / 10, mins % 10); end
         for (int i = 0; i < mins * 60 * tick_div + 50; i++) begin
            if (state === S_RUN && reach_zero === 1'b1) begin hit = 1'b1; break; end
            step();
         end
         step();
         n_checks += 2;
         if (!hit || state !== S_DONE)
            begin n_fail++; $display("FAIL timer%0d_done: hit=%b state=%0d want %0d", k, hit, state, S_DONE); end
         if (valve !== 1'b0 || count_en !== 1'b0)
            begin n_fail++; $display("FAIL timer%0d_valve_off: valve=%b count_en=%b want 0/0", k, valve, count_en); end
         for (int i = 0; i < (DONE_HOLD + 2) * tick_div + 4; i++) begin
            if (state !== S_DONE) break;
            if (tick_1hz) done_ticks++;
            step();
         end
         n_checks++;
         if (state !== S_IDLE || done_ticks != DONE_HOLD)
            begin n_fail++; $display("FAIL timer%0d_hold: state=%0d ticks=%0d want %0d/%0d", k, state, done_ticks, S_IDLE, DONE_HOLD); end
      end
      timer_on = 1'b0;
      tick_div = 4;
   endtask

   task automatic test_halt_resume();
      int lc0;
      bit ok;
      set_inputs(0, 1, 0, 0, 1);
      settle();
      press_start();
      wait_state(S_RUN, SYNC_STAGES + 6, ok);
      lc0 = load_count;
      lvl_l = 1'b0;
      wait_state(S_HALT, SYNC_STAGES + 3, ok);
      n_checks += 2;
      if (!ok) begin n_fail++; $display("FAIL halt_enter: state=%0d want %0d", state, S_HALT); end
      if (alarm !== 1'b1 || count_en !== 1'b0 || valve !== 1'b0)
         begin n_fail++; $display("FAIL halt_outputs: alarm=%b count_en=%b valve=%b want 1/0/0", alarm, count_en, valve); end
      repeat ($urandom_range(2, 10)) step();
      n_checks++;
      if (state !== S_HALT) begin n_fail++; $display("FAIL halt_stay: state=%0d want %0d", state, S_HALT); end
      lvl_l = 1'b1;
      wait_state(S_RUN, SYNC_STAGES + 3, ok);
      n_checks += 3;
      if (!ok || count_en !== 1'b1 || alarm !== 1'b0)
         begin n_fail++; $display("FAIL halt_resume: state=%0d count_en=%b alarm=%b want %0d/1/0", state, count_en, alarm, S_RUN); end
      if (load_count != lc0) begin n_fail++; $display("FAIL halt_no_reload: got %0d extra loads want 0", load_count - lc0); end
      if ({preset_dz_min, preset_und_min} !== {2'd1, 4'd0})
         begin n_fail++; $display("FAIL halt_preset: got %0d/%0d want 1/0", preset_dz_min, preset_und_min); end
      lvl_h = 1'b1;
      wait_state(S_HALT, SYNC_STAGES + 3, ok);
      n_checks++;
      if (!ok || alarm !== 1'b1) begin n_fail++; $display("FAIL halt_fault: state=%0d alarm=%b want %0d/1", state, alarm, S_HALT); end
      exit_to_idle("halt");
      lvl_h = 1'b0;
   endtask

   task automatic test_low_water();
      int lc0;
      bit ok;
      set_inputs(1, 0, 1, 0, 1);
      settle();
      press_start();
      wait_state(S_LOWW, SYNC_STAGES + 4, ok);
      n_checks++;
      if (!ok || alarm !== 1'b1) begin n_fail++; $display("FAIL loww_enter: state=%0d alarm=%b want %0d/1", state, alarm, S_LOWW); end
      lc0 = load_count;
      press_start();
      repeat (SYNC_STAGES + 4) step();
      n_checks++;
      if (state !== S_LOWW || load_count != lc0)
         begin n_fail++; $display("FAIL loww_start_ignored: state=%0d loads=%0d want %0d/0", state, load_count - lc0, S_LOWW); end
      lvl_m = 1'b1;
      wait_state(S_IDLE, SYNC_STAGES + 4, ok);
      n_checks++;
      if (!ok || alarm !== 1'b0) begin n_fail++; $display("FAIL loww_exit: state=%0d alarm=%b want %0d/0", state, alarm, S_IDLE); end
   endtask

   task automatic test_priority();
      bit ok, seen_halt = 1'b0;
      set_inputs(0, 1, 1, 1, 1);
      settle();
      press_start();
      wait_state(S_RUN, SYNC_STAGES + 6, ok);
      stop = 1'b1;
      step();
      stop = 1'b0;
      lvl_l = 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
         step();
         if (state === S_HALT) seen_halt = 1'b1;
      end
      rz_force = 1'b1;
      step();
      if (state === S_HALT) seen_halt = 1'b1;
      rz_force = 1'b0;
      n_checks += 2;
      if (state !== S_DONE || valve !== 1'b0) begin n_fail++; $display("FAIL prio_done: state=%0d valve=%b want %0d/0", state, valve, S_DONE); end
      for (int i = 0; i < 4; i++) begin
         step();
         if (state === S_HALT) seen_halt = 1'b1;
      end
      if (seen_halt) begin n_fail++; $display("FAIL prio_no_halt: halt seen=%b want 0", seen_halt); end
      lvl_l = 1'b1;
      wait_state(S_IDLE, (DONE_HOLD + 2) * tick_div + 4, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL prio_idle: state=%0d want %0d", state, S_IDLE); end
   endtask

   task automatic test_reset_mid_run();
      int lc0;
      bit ok;
      set_inputs(0, 1, 1, 1, 1);
      settle();
      press_start();
      wait_state(S_RUN, SYNC_STAGES + 6, ok);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks += 2;
      if (valve !== 1'b0 || count_en !== 1'b0 || load !== 1'b0 || alarm !== 1'b0)
         begin n_fail++; $display("FAIL rst_mid_outputs: valve=%b count_en=%b load=%b alarm=%b want 0/0/0/0", valve, count_en, load, alarm); end
      if (state !== S_IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d want %0d", state, S_IDLE); end
      step();
      rst_n = 1'b1;
      settle();
      lc0 = load_count;
      press_start();
      wait_state(S_RUN, SYNC_STAGES + 6, ok);
      n_checks++;
      if (!ok || load_count != lc0 + 1 || {preset_dz_min, preset_und_min} !== {2'd3, 4'd0})
         begin n_fail++; $display("FAIL rst_mid_reload: state=%0d loads=%0d preset=%0d/%0d want %0d/1/3/0", state, load_count - lc0, preset_dz_min, preset_und_min, S_RUN); end
      exit_to_idle("rstmid");
   endtask

   initial begin
      test_reset();
      test_drip_high();
      test_random_starts(12);
      test_timer_run(3);
      test_halt_resume();
      test_low_water();
      test_priority();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/irrigation_timer_ctrl.md
# irrigation_timer_ctrl

Controller that drives the irrigation countdown timer and reacts to it. It reads the tank level sensors and the irrigation-mode selection, then computes a minutes-only preset. It loads that preset into the mm:ss countdown, enables counting, and holds the irrigation valve open until the timer reports zero. It sits on the opposite side of the timer's load/count/reach-zero interface: the timer is the responder, this block is the initiator.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for all asynchronous sensor and button inputs (minimum 2).
- DONE_HOLD, 5, number of tick_1hz pulses spent in DONE before returning to IDLE (1..15).

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- tick_1hz  in  1  one-clk-wide enable pulse, once per second, synchronous to clk.
- lvl_h, lvl_m, lvl_l  in  1 each  tank level sensors, asynchronous; 1 = water at or above that sensor.
- mode_as, mode_gt  in  1 each  sprinkler / drip selection, asynchronous.
- start, stop  in  1 each  push-button requests, asynchronous, already debounced.
- reach_zero  in  1  timer reads 00:00; combinational from the timer registers.
- load  out  1  one-clk pulse; the timer captures the preset on this edge and clears the seconds.
- preset_dz_min  out  2  tens of minutes, BCD.
- preset_und_min  out  4  units of minutes, BCD.
- count_en  out  1  timer decrements on tick_1hz while this is high.
- valve  out  1  irrigation valve drive.
- alarm  out  1  low-water or sensor fault indicator.
- state  out  3  encoded FSM state, for display/debug.

## Operation
- All asynchronous inputs pass through SYNC_STAGES flops.
- start and stop are edge-detected on the synchronized signal (rising edge = one request).
- Level code is valid only if it is monotone: h implies m, and m implies l.
  - Non-monotone code (e.g. h=1, m=0) = sensor fault.
- Preset table, fixed and combinational from the synchronized inputs:
  - Drip (mode_gt): h→30, m→20, l→10 minutes.
  - Sprinkler (mode_as): h→15, m→10, l→05 minutes.
- Mode is valid only when exactly one of mode_as / mode_gt is set.
- FSM states:
  - IDLE=0: start with valid mode, valid level code and lvl_l=1 → LOAD. start with lvl_l=0 or a fault → LOWW. Invalid mode → start ignored.
  - LOAD=1: load=1 for exactly one clk; preset latched into output registers; → ARM.
  - ARM=2: one guard cycle; reach_zero ignored; → RUN.
  - RUN=3: valve=1, count_en=1.
    - reach_zero=1 → DONE.
    - stop → DONE.
    - lvl_l falls or a fault appears → HALT.
  - HALT=4: valve=0, count_en=0, alarm=1; the timer value is preserved.
    - Level restored and valid → RUN, with no reload.
    - stop → DONE.
  - DONE=5: valve=0, count_en=0. Counts DONE_HOLD ticks, then → IDLE.
  - LOWW=6: alarm=1. Level becomes valid with lvl_l=1 → IDLE; start is ignored while in LOWW.
- Simultaneous events in RUN, priority: stop > fault/low-level > reach_zero.
- Mode changes during RUN have no effect; the preset is frozen at LOAD.
- A preset of 00 is impossible by construction of the table; the ARM cycle still guards it.

## Timing
- Reset values: state=IDLE, load=0, preset_dz_min=0, preset_und_min=0, count_en=0, valve=0, alarm=0, DONE counter=0.
- Synchronized input to start edge detection: SYNC_STAGES+1 clk.
- start edge detected → load high on the next clk. Preset outputs are stable from that cycle and unchanged until the next LOAD.
- load → count_en high 2 clk later (ARM cycle in between).
- valve and count_en are registered.
  - They rise in the same cycle the FSM enters RUN.
  - They fall in the same cycle it leaves RUN.
- reach_zero sampled in RUN → valve low 1 clk later.
- Reset mid-operation: all outputs drop immediately, asynchronously; the timer is reloaded on the next start.

## Structure
- Package irrig_pkg holds:
  - the state enum, with its fixed encodings;
  - the preset constants (six BCD minute values);
  - a level-validity function.
- Sub-module sync_edge(SYNC_STAGES) provides the synchronizer plus rising-edge detector; instantiate it once per asynchronous input.
- FSM, preset mux and DONE counter live in the top module.

## Test plan
- Reset, then lvl_h=lvl_m=lvl_l=1, mode_gt=1, start → load pulse with preset 3/0; count_en and valve high 2 clk later.
- mode_as=1 and level code l-only, then start → preset 0/5. Assert reach_zero → valve=0 next clk, state=DONE, then IDLE after 5 ticks.
- In RUN, drop lvl_l → HALT with alarm=1 and count_en=0. Restore the level → RUN with no second load pulse.
- start with lvl_h=1 and lvl_m=0 → LOWW with alarm=1. Correct the code → IDLE.
- In RUN, assert stop and reach_zero and drop lvl_l in the same cycle → DONE; HALT is never entered.
- Deassert rst_n during RUN → valve, count_en and load are 0 before the next clk edge; state=IDLE.
